// File: rtl/bf_mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Contents: sequencing FSM states, grant encodings, data-port direction
// constants, latency counter width and a small grant helper.
`timescale 1ns/1ps

package bf_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_ACK   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    // Data-port direction as driven by the core on d_dir.
    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    // Wide enough for mem_latency-1 with mem_latency up to 7.
    localparam int unsigned LAT_W = 3;

    function automatic grant_e other_port(input grant_e g);
        return (g == GRANT_I) ? GRANT_D : GRANT_I;
    endfunction

endpackage

// File: rtl/bf_rr_arbiter2.sv
// Two-requester round-robin grant logic.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   req_i, req_d   pending requests from the fetch and data ports
//   accept         parent has taken the current grant; remember it
//   grant_valid    at least one request pending
//   grant          port to serve; on contention, the one not served last
`timescale 1ns/1ps

module bf_rr_arbiter2
    import bf_mem_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   req_i,
    input  logic   req_d,
    input  logic   accept,
    output logic   grant_valid,
    output grant_e grant
);

    grant_e last_grant_q;
    grant_e last_grant_d;

    always_comb begin
        grant_valid = req_i | req_d;
        if (req_i && req_d) begin
            grant = other_port(last_grant_q);
        end else if (req_d) begin
            grant = GRANT_D;
        end else begin
            grant = GRANT_I;
        end
        last_grant_d = accept ? grant : last_grant_q;
    end

    // Starting from D means the first contention goes to the fetch port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/bf_mem_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch
// port (read-only) and the data port (read/write), one access at a time.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   i_req/i_addr/i_ack/i_rdata         four-phase fetch slave port
//   d_req/d_dir/d_addr/d_wdata/
//   d_ack/d_rdata                      four-phase data slave port
//   mem_en/mem_we/mem_addr/mem_wdata   RAM strobe and write side
//   mem_rdata                          RAM read data, mem_latency after mem_en
// Fetch addresses map to memory zero-extended; data address n maps to
// d_base + n. Overlapping regions are allowed.
`timescale 1ns/1ps

module bf_mem_arbiter
    import bf_mem_arbiter_pkg::*;
#(
    parameter int unsigned             i_addr_width = 16,
    parameter int unsigned             d_addr_width = 8,
    parameter int unsigned             m_addr_width = 17,
    parameter logic [m_addr_width-1:0] d_base       = 17'h10000,
    parameter int unsigned             mem_latency  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_req,
    input  logic [i_addr_width-1:0] i_addr,
    output logic                    i_ack,
    output logic [7:0]              i_rdata,
    input  logic                    d_req,
    input  logic                    d_dir,
    input  logic [d_addr_width-1:0] d_addr,
    input  logic [7:0]              d_wdata,
    output logic                    d_ack,
    output logic [7:0]              d_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [m_addr_width-1:0] mem_addr,
    output logic [7:0]              mem_wdata,
    input  logic [7:0]              mem_rdata
);

    localparam longint unsigned D_TOP =
        longint'(d_base) + (64'd1 << d_addr_width) - 64'd1;
    localparam longint unsigned M_TOP = (64'd1 << m_addr_width) - 64'd1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(mem_latency - 1);

    if (D_TOP > M_TOP) begin : g_bad_d_range
        $fatal(1, "bf_mem_arbiter: data window runs past the memory space");
    end
    if (i_addr_width > m_addr_width) begin : g_bad_i_width
        $fatal(1, "bf_mem_arbiter: fetch address wider than memory address");
    end
    if (mem_latency < 1 || mem_latency > 7) begin : g_bad_latency
        $fatal(1, "bf_mem_arbiter: mem_latency must be 1..7");
    end

    arb_state_e              state_q, state_d;
    grant_e                  gnt_q, gnt_d;
    logic                    wr_q, wr_d;
    logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
    logic                    mem_en_q, mem_en_d;
    logic                    mem_we_q, mem_we_d;
    logic [m_addr_width-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]              mem_wdata_q, mem_wdata_d;
    logic                    i_ack_q, i_ack_d;
    logic                    d_ack_q, d_ack_d;
    logic [7:0]              i_rdata_q, i_rdata_d;
    logic [7:0]              d_rdata_q, d_rdata_d;

    logic   accept;
    logic   grant_valid;
    grant_e grant;
    logic   gnt_req;

    bf_rr_arbiter2 u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (i_req),
        .req_d       (d_req),
        .accept      (accept),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        lat_cnt_d   = lat_cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = i_ack_q;
        d_ack_d     = d_ack_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        accept      = 1'b0;
        gnt_req     = (gnt_q == GRANT_I) ? i_req : d_req;

        unique case (state_q)
            ARB_IDLE: begin
                // Outputs are registered, so strobes set here appear
                // during the single ISSUE cycle.
                if (grant_valid) begin
                    accept   = 1'b1;
                    gnt_d    = grant;
                    state_d  = ARB_ISSUE;
                    mem_en_d = 1'b1;
                    if (grant == GRANT_I) begin
                        wr_d       = 1'b0;
                        mem_addr_d = m_addr_width'(i_addr);
                    end else begin
                        wr_d        = (d_dir == DIR_WRITE);
                        mem_addr_d  = d_base + m_addr_width'(d_addr);
                        mem_wdata_d = d_wdata;
                    end
                    mem_we_d = wr_d;
                end
            end
            ARB_ISSUE: begin
                lat_cnt_d = LAT_LOAD;
                state_d   = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (lat_cnt_q == '0) begin
                    if (!wr_q) begin
                        if (gnt_q == GRANT_I) begin
                            i_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                    // A requester that gave up early gets no ack.
                    if (gnt_req) begin
                        state_d = ARB_ACK;
                        if (gnt_q == GRANT_I) begin
                            i_ack_d = 1'b1;
                        end else begin
                            d_ack_d = 1'b1;
                        end
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            ARB_ACK: begin
                if (!gnt_req) begin
                    i_ack_d = 1'b0;
                    d_ack_d = 1'b0;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= GRANT_I;
            wr_q        <= 1'b0;
            lat_cnt_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            wr_q        <= wr_d;
            lat_cnt_q   <= lat_cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
